shared_ram_responder: RTL and testbench

//  Responder end of the FemtoRV32 memory bus. Owns the shared PIM-side RAM, serves two initiators:

---
 rtl/shared_ram_responder.sv | 176 +++++++++++++++++
 tb/tb_shared_ram_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_ram_responder.sv
// Shared PIM-side RAM responder: arbitrates the main and PIM bus ports onto one word array and holds the PIM control word.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed main-first priority.
module shared_ram_responder #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] CTRL_ADDR   = 32'h0000_0FFC,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_addr,
  input  logic        m_rstrb,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_wmask,
  output logic [31:0] m_rdata,
  output logic        m_rbusy,
  output logic        m_wbusy,
  input  logic [31:0] p_addr,
  input  logic        p_rstrb,
  input  logic [31:0] p_wdata,
  input  logic [3:0]  p_wmask,
  output logic [31:0] p_rdata,
  output logic        p_rbusy,
  output logic        p_wbusy,
  output logic        pim_sel
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [9:0] CTRL_IDX = CTRL_ADDR[11:2];

  logic [31:0] mem [DEPTH];

  // Index 0 is the main port, index 1 the PIM port.
  logic [ADDR_W-1:0] req_idx   [2];
  logic [31:0]       req_wdata [2];
  logic [3:0]        req_wmask [2];
  logic [1:0]        req_hit;
  logic [1:0]        req_rstrb;
  logic              unused_addr;

  assign req_idx[0]   = m_addr[ADDR_W+1:2];
  assign req_idx[1]   = p_addr[ADDR_W+1:2];
  assign req_hit[0]   = (m_addr[11:2] == CTRL_IDX);
  assign req_hit[1]   = (p_addr[11:2] == CTRL_IDX);
  assign req_wdata[0] = m_wdata;
  assign req_wdata[1] = p_wdata;
  assign req_wmask[0] = m_wmask;
  assign req_wmask[1] = p_wmask;
  assign req_rstrb    = {p_rstrb, m_rstrb};
  assign unused_addr  = ^{m_addr, p_addr};

  logic [1:0]        pend_rd_q, pend_wr_q, hit_q;
  logic [ADDR_W-1:0] idx_q   [2];
  logic [31:0]       wdata_q [2];
  logic [3:0]        wmask_q [2];
  logic [31:0]       rdata_q [2];
  logic              ctrl_q;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt_q, gnt_d;
  logic       sel, pick, commit, do_wr;
  logic [1:0] pend;

  assign pend  = pend_rd_q | pend_wr_q;
  assign do_wr = commit & pend_wr_q[sel];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;
  assign pick = (&pend) ? ~last_q : pend[1];
`else
  assign pick = ~pend[0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel     = gnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|pend) begin
          sel   = pick;
          gnt_d = pick;
          // Zero wait states: grant and commit happen on the same edge.
          if (WAIT_STATES == 0) begin
            commit = 1'b1;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      gnt_q      <= 1'b0;
      ctrl_q     <= 1'b0;
      pend_rd_q  <= 2'b00;
      pend_wr_q  <= 2'b00;
      rdata_q[0] <= 32'd0;
      rdata_q[1] <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      for (int i = 0; i < 2; i++) begin
        if (commit && (sel == 1'(i))) begin
          pend_rd_q[i] <= 1'b0;
          pend_wr_q[i] <= 1'b0;
          if (pend_rd_q[i])
            rdata_q[i] <= hit_q[i] ? {31'd0, ctrl_q} : mem[idx_q[i]];
        end else if (!pend[i]) begin
          // A write strobe wins over a simultaneous read strobe.
          if (|req_wmask[i])
            pend_wr_q[i] <= 1'b1;
          else if (req_rstrb[i])
            pend_rd_q[i] <= 1'b1;
        end
      end
      if (do_wr && hit_q[sel] && wmask_q[sel][0])
        ctrl_q <= wdata_q[sel][0];
`ifdef ARB_ROUND_ROBIN_EN
      if (commit)
        last_q <= sel;
`endif
    end
  end

  // Request latches and array: only meaningful while the matching pending flag is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && ((|req_wmask[i]) || req_rstrb[i])) begin
        idx_q[i]   <= req_idx[i];
        hit_q[i]   <= req_hit[i];
        wdata_q[i] <= req_wdata[i];
        wmask_q[i] <= req_wmask[i];
      end
    end
    if (do_wr && !hit_q[sel]) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[sel][b])
          mem[idx_q[sel]][8*b +: 8] <= wdata_q[sel][8*b +: 8];
      end
    end
  end

  assign m_rdata = rdata_q[0];
  assign p_rdata = rdata_q[1];
  assign m_rbusy = pend_rd_q[0];
  assign m_wbusy = pend_wr_q[0];
  assign p_rbusy = pend_rd_q[1];
  assign p_wbusy = pend_wr_q[1];
  assign pim_sel = ctrl_q;

endmodule

// File: tb/tb_shared_ram_responder.sv
// Scoreboard bench for shared_ram_responder: a zero-wait-state instance driven randomly against a
// behavioural memory model, plus a three-wait-state instance exercised with directed reset/latency cases.
module tb_shared_ram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m_addr = '0, m_wdata = '0, p_addr = '0, p_wdata = '0;
  logic        m_rstrb = 1'b0, p_rstrb = 1'b0;
  logic [3:0]  m_wmask = '0, p_wmask = '0;
  logic [31:0] m_rdata, p_rdata;
  logic        m_rbusy, m_wbusy, p_rbusy, p_wbusy, pim_sel;

  logic [31:0] w_addr = '0, w_wdata = '0;
  logic        w_rstrb = 1'b0;
  logic [3:0]  w_wmask = '0;
  logic [31:0] w_rdata, wp_rdata;
  logic        w_rbusy, w_wbusy, wp_rbusy, wp_wbusy, w_pim;

  always #5 clk = ~clk;

  shared_ram_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut (
    .clk(clk), .reset(reset),
    .m_addr(m_addr), .m_rstrb(m_rstrb), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rdata(m_rdata), .m_rbusy(m_rbusy), .m_wbusy(m_wbusy),
    .p_addr(p_addr), .p_rstrb(p_rstrb), .p_wdata(p_wdata), .p_wmask(p_wmask),
    .p_rdata(p_rdata), .p_rbusy(p_rbusy), .p_wbusy(p_wbusy),
    .pim_sel(pim_sel)
  );

  shared_ram_responder #(.ADDR_W(10), .WAIT_STATES(3)) dut_ws (
    .clk(clk), .reset(reset),
    .m_addr(w_addr), .m_rstrb(w_rstrb), .m_wdata(w_wdata), .m_wmask(w_wmask),
    .m_rdata(w_rdata), .m_rbusy(w_rbusy), .m_wbusy(w_wbusy),
    .p_addr(32'd0), .p_rstrb(1'b0), .p_wdata(32'd0), .p_wmask(4'd0),
    .p_rdata(wp_rdata), .p_rbusy(wp_rbusy), .p_wbusy(wp_wbusy),
    .pim_sel(w_pim)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: word array, control bit, last-served port.
  typedef struct {
    bit          wr;
    logic [31:0] d;
    int          len;
  } exp_t;

  logic [31:0] model_mem [1024];
  bit          model_ctrl = 1'b0;
  bit          last_pim = 1'b1;
  exp_t        expq [2][$];

  task automatic model_op(input int port, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] mk, input int len);
    exp_t e;
    logic [9:0] w;
    w = a[11:2];
    e.wr = wr; e.len = len; e.d = '0;
    if (wr) begin
      if (w == 10'h3FF) begin
        if (mk[0]) model_ctrl = d[0];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mk[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
      end
    end else begin
      e.d = (w == 10'h3FF) ? {31'd0, model_ctrl} : model_mem[w];
    end
    expq[port].push_back(e);
  endtask

  function automatic logic [31:0] mk_addr(input int w);
    logic [31:0] r;
    logic [9:0]  wi;
    r  = $urandom();
    wi = w[9:0];
    return {r[31:12], wi, r[1:0]};
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_rbusy | m_wbusy | p_rbusy | p_wbusy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still set after %0d cycles, required idle", n);
    end
  endtask

  task automatic issue(input bit me, input bit mw, input logic [31:0] ma, input logic [31:0] md,
                       input logic [3:0] mm, input bit pe, input bit pw, input logic [31:0] pa,
                       input logic [31:0] pd, input logic [3:0] pm);
    bit pim_first;
    @(negedge clk);
    wait_idle();
    chk("pim_sel", {31'd0, pim_sel}, {31'd0, model_ctrl});
    pim_first = 1'b0;
    if (me && pe) begin
`ifdef ARB_ROUND_ROBIN_EN
      pim_first = !last_pim;
`endif
      if (pim_first) begin
        model_op(1, pw, pa, pd, pm, 1);
        model_op(0, mw, ma, md, mm, 2);
      end else begin
        model_op(0, mw, ma, md, mm, 1);
        model_op(1, pw, pa, pd, pm, 2);
      end
      last_pim = !pim_first;
    end else if (me) begin
      model_op(0, mw, ma, md, mm, 1);
      last_pim = 1'b0;
    end else if (pe) begin
      model_op(1, pw, pa, pd, pm, 1);
      last_pim = 1'b1;
    end
    m_addr = ma; m_wdata = md; m_wmask = (me && mw) ? mm : 4'h0;
    m_rstrb = me && (!mw || ($urandom_range(0, 1) == 1));
    p_addr = pa; p_wdata = pd; p_wmask = (pe && pw) ? pm : 4'h0;
    p_rstrb = pe && (!pw || ($urandom_range(0, 1) == 1));
    @(posedge clk);
    #1;
    m_rstrb = 1'b0; m_wmask = 4'h0; p_rstrb = 1'b0; p_wmask = 4'h0;
  endtask

  // Monitor: a busy falling edge marks a completed access on that port.
  int bcnt [2] = '{0, 0};
  bit bwr [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    logic [1:0]  rb, wb;
    logic [31:0] rd [2];
    exp_t        e;
    rb = {p_rbusy, m_rbusy};
    wb = {p_wbusy, m_wbusy};
    rd[0] = m_rdata;
    rd[1] = p_rdata;
    for (int i = 0; i < 2; i++) begin
      if (rb[i] | wb[i]) begin
        bcnt[i]++;
        bwr[i] = wb[i];
      end else if (bcnt[i] != 0) begin
        if (expq[i].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_response port%0d: got busy for %0d cycles, required none", i, bcnt[i]);
        end else begin
          e = expq[i].pop_front();
          chk($sformatf("busy_len_port%0d", i), 32'(bcnt[i]), 32'(e.len));
          chk($sformatf("kind_port%0d", i), {31'd0, bwr[i]}, {31'd0, e.wr});
          if (!e.wr) chk($sformatf("rdata_port%0d", i), rd[i], e.d);
        end
        bcnt[i] = 0;
      end
    end
  end

  task automatic w_op(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] mk);
    @(negedge clk);
    w_addr = a; w_wdata = d; w_wmask = wr ? mk : 4'h0; w_rstrb = !wr;
    @(posedge clk);
    #1;
    w_rstrb = 1'b0; w_wmask = 4'h0;
  endtask

  task automatic w_busy_len(output int n);
    n = 0;
    @(negedge clk);
    while ((w_rbusy | w_wbusy) && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit me, pe, mw, pw;
    int mwd, pwd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_m_rdata", m_rdata, 32'd0);
    chk("rst_p_rdata", p_rdata, 32'd0);
    chk("rst_busy", {28'd0, m_rbusy, m_wbusy, p_rbusy, p_wbusy}, 32'd0);
    chk("rst_pim_sel", {31'd0, pim_sel}, 32'd0);

    // Wait-state instance: latency, aliasing, reset during an access.
    w_op(1'b1, 32'h0000_0FFC, 32'd1, 4'h1);
    w_busy_len(n);
    chk("ws_ctrl_wbusy_len", 32'(n), 32'd4);
    chk("ws_pim_sel_on", {31'd0, w_pim}, 32'd1);
    w_op(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF);
    w_busy_len(n);
    chk("ws_wbusy_len", 32'(n), 32'd4);
    w_op(1'b0, 32'h0000_1010, 32'd0, 4'h0);
    w_busy_len(n);
    chk("ws_alias_rbusy_len", 32'(n), 32'd4);
    chk("ws_alias_rdata", w_rdata, 32'h1234_5678);
    w_op(1'b0, 32'h0000_0010, 32'd0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("ws_mid_access_busy", {31'd0, w_rbusy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("ws_abort_rbusy", {31'd0, w_rbusy}, 32'd0);
    chk("ws_abort_rdata", w_rdata, 32'd0);
    chk("ws_abort_pim_sel", {31'd0, w_pim}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_ctrl = 1'b0;
    last_pim = 1'b1;
    w_op(1'b0, 32'h0000_0010, 32'd0, 4'h0);
    w_busy_len(n);
    chk("ws_after_reset_rbusy_len", 32'(n), 32'd4);
    chk("ws_after_reset_rdata", w_rdata, 32'h1234_5678);

    // Fill the words the random phase uses, both ports writing at once.
    for (int w = 0; w < 8; w++)
      issue(1'b1, 1'b1, mk_addr(w), $urandom(), 4'hF, 1'b1, 1'b1, mk_addr(w + 8), $urandom(), 4'hF);

    issue(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    issue(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    @(negedge clk); wait_idle();
    chk("full_word_readback", m_rdata, 32'hDEAD_BEEF);

    issue(1'b1, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    issue(1'b1, 1'b1, 32'h20, 32'h0000_00AA, 4'h1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    issue(1'b1, 1'b0, 32'h20, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    @(negedge clk); wait_idle();
    chk("byte_mask_readback", m_rdata, 32'h1122_33AA);

    repeat (2)
      issue(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0);

    issue(1'b1, 1'b1, 32'h0FFC, 32'd1, 4'h1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    issue(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 1'b1, 32'h0FFC, 32'd0, 4'hF);
    issue(1'b1, 1'b0, 32'h0FFC, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    @(negedge clk); wait_idle();
    chk("ctrl_readback", m_rdata, 32'd0);
    chk("ctrl_pim_sel_off", {31'd0, pim_sel}, 32'd0);

    for (int it = 0; it < 300; it++) begin
      me = ($urandom_range(0, 3) != 0);
      pe = ($urandom_range(0, 3) != 0);
      if (!me && !pe) me = 1'b1;
      mw = ($urandom_range(0, 1) == 1);
      pw = ($urandom_range(0, 1) == 1);
      mwd = $urandom_range(0, 16);
      pwd = $urandom_range(0, 16);
      if (mwd == 16) mwd = 10'h3FF;
      if (pwd == 16) pwd = 10'h3FF;
      issue(me, mw, mk_addr(mwd), $urandom(), 4'($urandom_range(1, 15)),
            pe, pw, mk_addr(pwd), $urandom(), 4'($urandom_range(1, 15)));
    end

    @(negedge clk); wait_idle();
    repeat (2) @(negedge clk);
    chk("queue_drain", 32'(expq[0].size() + expq[1].size()), 32'd0);
    chk("final_pim_sel", {31'd0, pim_sel}, {31'd0, model_ctrl});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
